// File: rtl/sici_pcs_blk_sync.sv
// ---------------------------------------------------------------------------
// sici_pcs_blk_sync
// Receive-side PCS block synchronizer. Takes unaligned parallel words from
// the deserializer, hunts for the 2-bit sync-header boundary by bit-slipping,
// and delivers aligned words with the SH in [FW-1:FW-2]. Syn_OK qualifies
// frame sync for the downstream overhead extractor.
//
// Ports:
//   Ck          clock
//   Rs          synchronous active-high reset (overrides CE)
//   CE          clock enable; all state advances only when high
//   Raw_Dat_i   unaligned input word, MSB is the earliest received bit
//   PCS_Dat_o   aligned word, one CE cycle latency, SH in [FW-1:FW-2]
//   Syn_OK      block lock indicator
//   Slip_o      one-cycle pulse on every bit slip
//   Slip_Pos    current alignment offset (0..FW-1)
//   Lo_Syn_Pls  one-cycle pulse when lock is lost
// ---------------------------------------------------------------------------
module sici_pcs_blk_sync #(
   parameter int FW       = 32,
   parameter int LOCK_CNT = 16,
   parameter int WIN_LEN  = 64,
   parameter int BAD_MAX  = 8,
   parameter int SLIP_GAP = 2
) (
   input  logic                    Ck,
   input  logic                    Rs,
   input  logic                    CE,
   input  logic [FW-1:0]           Raw_Dat_i,
   output logic [FW-1:0]           PCS_Dat_o,
   output logic                    Syn_OK,
   output logic                    Slip_o,
   output logic [$clog2(FW)-1:0]   Slip_Pos,
   output logic                    Lo_Syn_Pls
);

   localparam int SPW = $clog2(FW);

   localparam logic [7:0]     LOCK_CNT_C = 8'(LOCK_CNT);
   localparam logic [7:0]     WIN_LEN_C  = 8'(WIN_LEN);
   localparam logic [7:0]     BAD_MAX_C  = 8'(BAD_MAX);
   localparam logic [3:0]     SLIP_GAP_C = 4'(SLIP_GAP);
   // FW need not be a power of two, so the wrap point is an explicit compare.
   localparam logic [SPW-1:0] SP_LAST    = SPW'(FW - 1);

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_GAP  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   state_t          state_q;
   logic [FW-1:0]   prev_q;
   logic [FW-1:0]   dat_q;
   logic            syn_ok_q;
   logic            slip_q;
   logic            lo_syn_q;
   logic [SPW-1:0]  slip_pos_q;
   logic [7:0]      good_q;
   logic [7:0]      win_q;
   logic [7:0]      bad_q;
   logic [3:0]      gap_q;

   logic [2*FW-1:0] win_w;
   logic [SPW:0]    sel_idx;
   logic [FW-1:0]   aligned_d;
   logic            sh_ok;
   logic [7:0]      good_d;
   logic [7:0]      win_d;
   logic [7:0]      bad_d;
   logic [3:0]      gap_d;

   // Counters saturate instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // The previous word supplies the bits that slide in as the offset grows;
   // offset 0 passes the raw word straight through.
   assign win_w   = {prev_q, Raw_Dat_i};
   assign sel_idx = {1'b0, slip_pos_q};

   // NOTE: every always_comb output is assigned first, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      aligned_d = win_w[sel_idx +: FW];
      sh_ok     = aligned_d[FW-1] ^ aligned_d[FW-2];
      good_d    = sat_inc8(good_q);
      win_d     = sat_inc8(win_q);
      bad_d     = sat_inc8(bad_q);
      gap_d     = sat_inc4(gap_q);
   end

   // NOTE: all state is updated with non-blocking assignments so every branch
   // reads the pre-edge values, independent of statement order.
   always_ff @(posedge Ck) begin
      if (Rs) begin
         state_q    <= ST_HUNT;
         prev_q     <= '0;
         dat_q      <= '0;
         syn_ok_q   <= 1'b0;
         slip_q     <= 1'b0;
         lo_syn_q   <= 1'b0;
         slip_pos_q <= '0;
         good_q     <= '0;
         win_q      <= '0;
         bad_q      <= '0;
         gap_q      <= '0;
      end else begin
         // Pulses default low; only the transitions below raise them.
         slip_q   <= 1'b0;
         lo_syn_q <= 1'b0;
         if (CE) begin
            prev_q <= Raw_Dat_i;
            dat_q  <= aligned_d;
            unique case (state_q)
               ST_HUNT: begin
                  if (sh_ok) begin
                     good_q <= good_d;
                     if (good_d == LOCK_CNT_C) begin
                        state_q  <= ST_LOCK;
                        syn_ok_q <= 1'b1;
                        win_q    <= '0;
                        bad_q    <= '0;
                     end
                  end else begin
                     good_q     <= '0;
                     slip_pos_q <= (slip_pos_q == SP_LAST) ? '0 : slip_pos_q + 1'b1;
                     slip_q     <= 1'b1;
                     gap_q      <= '0;
                     state_q    <= ST_GAP;
                  end
               end
               ST_GAP: begin
                  // Blank the words straddling the slip before testing again.
                  gap_q <= gap_d;
                  if (gap_d == SLIP_GAP_C) begin
                     state_q <= ST_HUNT;
                     good_q  <= '0;
                  end
               end
               ST_LOCK: begin
                  // Loss of lock wins over the window boundary. No slip here:
                  // the current offset is retried first.
                  if (!sh_ok && (bad_d == BAD_MAX_C)) begin
                     state_q  <= ST_HUNT;
                     syn_ok_q <= 1'b0;
                     lo_syn_q <= 1'b1;
                     good_q   <= '0;
                  end else if (win_d == WIN_LEN_C) begin
                     win_q <= '0;
                     bad_q <= '0;
                  end else begin
                     win_q <= win_d;
                     if (!sh_ok) begin
                        bad_q <= bad_d;
                     end
                  end
               end
               default: state_q <= ST_HUNT;
            endcase
         end
      end
   end

   assign PCS_Dat_o  = dat_q;
   assign Syn_OK     = syn_ok_q;
   assign Slip_o     = slip_q;
   assign Slip_Pos   = slip_pos_q;
   assign Lo_Syn_Pls = lo_syn_q;

endmodule

// File: tb/tb_sici_pcs_blk_sync.sv
// ---------------------------------------------------------------------------
// tb_sici_pcs_blk_sync
// Self-checking bench for sici_pcs_blk_sync (FW=32 defaults). A serial stream
// of 32-bit blocks (SH=01, random payload) is presented shifted by SHIFT bits;
// a behavioural model of the synchronizer predicts every output each edge,
// and directed checks cover slip cadence, acquisition offset, window
// tolerance, loss/relock, CE gating and mid-lock reset.
// ---------------------------------------------------------------------------
module tb_sici_pcs_blk_sync;

   localparam int FW       = 32;
   localparam int LOCK_CNT = 16;
   localparam int WIN_LEN  = 64;
   localparam int BAD_MAX  = 8;
   localparam int SLIP_GAP = 2;
   localparam int SHIFT    = 5;

   logic          Ck = 1'b0;
   logic          Rs = 1'b1;
   logic          CE = 1'b0;
   logic [FW-1:0] Raw_Dat_i = '0;
   logic [FW-1:0] PCS_Dat_o;
   logic          Syn_OK;
   logic          Slip_o;
   logic [4:0]    Slip_Pos;
   logic          Lo_Syn_Pls;

   sici_pcs_blk_sync #(
      .FW       (FW),
      .LOCK_CNT (LOCK_CNT),
      .WIN_LEN  (WIN_LEN),
      .BAD_MAX  (BAD_MAX),
      .SLIP_GAP (SLIP_GAP)
   ) dut (
      .Ck         (Ck),
      .Rs         (Rs),
      .CE         (CE),
      .Raw_Dat_i  (Raw_Dat_i),
      .PCS_Dat_o  (PCS_Dat_o),
      .Syn_OK     (Syn_OK),
      .Slip_o     (Slip_o),
      .Slip_Pos   (Slip_Pos),
      .Lo_Syn_Pls (Lo_Syn_Pls)
   );

   always #5 Ck = ~Ck;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int M_HUNT  = 0;
   localparam int M_BLANK = 1;
   localparam int M_LOCK  = 2;

   logic [FW-1:0] m_prev = '0;
   logic [FW-1:0] m_dat  = '0;
   int            m_sp   = 0;
   int            m_mode = M_HUNT;
   int            m_good = 0;
   int            m_gap  = 0;
   int            m_win  = 0;
   int            m_bad  = 0;
   bit            m_sync = 0;
   bit            m_slip = 0;
   bit            m_los  = 0;

   task automatic model_step(input logic [FW-1:0] raw, input bit ce, input bit rs);
      logic [2*FW-1:0] w;
      logic [FW-1:0]   a;
      bit              ok;
      m_slip = 0;
      m_los  = 0;
      if (rs) begin
         m_prev = '0; m_dat = '0; m_sp = 0; m_mode = M_HUNT;
         m_good = 0; m_gap = 0; m_win = 0; m_bad = 0; m_sync = 0;
         return;
      end
      if (!ce) return;
      w  = {m_prev, raw};
      w  = w >> m_sp;
      a  = w[FW-1:0];
      ok = (a[FW-1] != a[FW-2]);
      m_prev = raw;
      m_dat  = a;
      case (m_mode)
         M_HUNT: begin
            if (ok) begin
               m_good++;
               if (m_good == LOCK_CNT) begin
                  m_mode = M_LOCK; m_sync = 1; m_win = 0; m_bad = 0;
               end
            end else begin
               m_good = 0;
               m_sp   = (m_sp + 1) % FW;
               m_slip = 1;
               m_gap  = 0;
               m_mode = M_BLANK;
            end
         end
         M_BLANK: begin
            m_gap++;
            if (m_gap == SLIP_GAP) begin
               m_mode = M_HUNT; m_good = 0;
            end
         end
         default: begin
            m_win++;
            if (!ok) m_bad++;
            if (!ok && m_bad == BAD_MAX) begin
               m_mode = M_HUNT; m_sync = 0; m_los = 1; m_good = 0;
            end else if (m_win == WIN_LEN) begin
               m_win = 0; m_bad = 0;
            end
         end
      endcase
   endtask

   // One clock: drive on the falling edge, model the rising edge, sample 1ns later.
   task automatic step(input logic [FW-1:0] raw, input bit ce, input bit rs);
      @(negedge Ck);
      Raw_Dat_i = raw;
      CE        = ce;
      Rs        = rs;
      @(posedge Ck);
      model_step(raw, ce, rs);
      #1;
      check("dat",      PCS_Dat_o,  m_dat);
      check("syn_ok",   Syn_OK,     m_sync);
      check("slip",     Slip_o,     m_slip);
      check("slip_pos", Slip_Pos,   m_sp);
      check("lo_syn",   Lo_Syn_Pls, m_los);
   endtask

   // ---------------- shifted block stream ----------------
   logic [FW-1:0] cur_blk;
   logic [FW-1:0] nxt_blk;
   int            tx_idx    = 0;
   int            lock_base = -1;
   int            bad_pct   = 0;
   bit            bad_map [0:511];

   function automatic logic [FW-1:0] make_blk(input bit bad);
      logic [FW-1:0] b;
      b = $urandom;
      if (bad) b[FW-1:FW-2] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      else     b[FW-1:FW-2] = 2'b01;
      return b;
   endfunction

   // Word index w carries block w; bad_map is indexed by words since lock.
   function automatic bit is_bad(input int w);
      int i;
      i = w - lock_base - 1;
      if (lock_base < 0 || i < 0 || i > 511) return 0;
      return bad_map[i];
   endfunction

   task automatic send(input bit ce, input bit rs, output logic [FW-1:0] blk_out);
      logic [2*FW-1:0] pair;
      logic [FW-1:0]   raw;
      bit              bad;
      pair    = {cur_blk, nxt_blk} << SHIFT;
      raw     = pair[2*FW-1:FW];
      blk_out = cur_blk;
      if (!ce && !rs) raw = $urandom;
      step(raw, ce, rs);
      if (ce) begin
         tx_idx++;
         cur_blk = nxt_blk;
         bad     = is_bad(tx_idx + 1) || ($urandom_range(0, 99) < bad_pct);
         nxt_blk = make_blk(bad);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [FW-1:0] blk;
      int cnt;
      int last;
      int n_lo;
      int n_slip;
      int n_bad_pulse;

      for (int i = 0; i < 512; i++) bad_map[i] = 0;
      for (int i = 121; i <= 134; i++) bad_map[i] = 1;  // 7 at end of window 1, 7 at start of window 2
      for (int i = 312; i <= 319; i++) bad_map[i] = 1;  // 8th bad lands on the last word of window 4
      cur_blk = make_blk(0);
      nxt_blk = make_blk(0);

      // Reset with random input
      repeat (3) step($urandom, 1'b1, 1'b1);
      check("rst_dat",      PCS_Dat_o,  0);
      check("rst_syn",      Syn_OK,     0);
      check("rst_slip",     Slip_o,     0);
      check("rst_pos",      Slip_Pos,   0);
      check("rst_lo",       Lo_Syn_Pls, 0);

      // Constant zero: slip every 1+SLIP_GAP cycles, offset wraps at FW
      cnt  = 0;
      last = 1 - (1 + SLIP_GAP);
      for (int i = 1; i <= 99; i++) begin
         step('0, 1'b1, 1'b0);
         if (Slip_o) begin
            cnt++;
            check("slip_period", i - last, 1 + SLIP_GAP);
            last = i;
            if (cnt == 32) check("slip_wrap0", Slip_Pos, 0);
         end
      end
      check("slip_count", cnt, 33);
      check("slip_pos_end", Slip_Pos, 1);

      // Acquire shifted stream
      step('0, 1'b1, 1'b1);
      cnt = 0;
      while (!Syn_OK && cnt < 2000) begin
         send(1'b1, 1'b0, blk);
         cnt++;
      end
      check("acq_lock", Syn_OK, 1);
      check("acq_pos",  Slip_Pos, SHIFT);
      lock_base = tx_idx - 1;

      // Payload, window tolerance, loss at window end
      n_lo = 0;
      for (int i = 0; i <= 319; i++) begin
         send(1'b1, 1'b0, blk);
         if (i < 20) begin
            check("payload", PCS_Dat_o, blk);
            check("sh01",    PCS_Dat_o[FW-1:FW-2], 2'b01);
         end
         if (i < 319 && Lo_Syn_Pls) n_lo++;
         if (i == 127) check("win1_hold", Syn_OK, 1);
         if (i == 191) check("win2_hold", Syn_OK, 1);
         if (i == 319) begin
            check("loss_pulse", Lo_Syn_Pls, 1);
            check("loss_syn",   Syn_OK, 0);
            check("loss_pos",   Slip_Pos, SHIFT);
         end
      end
      check("no_early_loss", n_lo, 0);

      // Relock on clean data without slipping
      cnt    = 0;
      n_slip = 0;
      while (!Syn_OK && cnt < 100) begin
         send(1'b1, 1'b0, blk);
         cnt++;
         if (Slip_o) n_slip++;
      end
      check("relock_words",  cnt, LOCK_CNT);
      check("relock_noslip", n_slip, 0);
      check("relock_pos",    Slip_Pos, SHIFT);

      // CE toggling while locked: no pulses, lock held
      n_bad_pulse = 0;
      for (int i = 0; i < 40; i++) begin
         send((i % 2) == 0, 1'b0, blk);
         if ((i % 2) == 1 && (Slip_o || Lo_Syn_Pls)) n_bad_pulse++;
      end
      check("ce_no_pulse", n_bad_pulse, 0);
      check("ce_hold",     Syn_OK, 1);

      // Reset mid-lock
      send(1'b1, 1'b1, blk);
      check("midrst_syn", Syn_OK, 0);
      check("midrst_pos", Slip_Pos, 0);
      check("midrst_lo",  Lo_Syn_Pls, 0);

      // Reacquire with CE toggling
      cnt = 0;
      while (!Syn_OK && cnt < 4000) begin
         send((cnt % 2) == 0, 1'b0, blk);
         cnt++;
      end
      check("ce_acq_lock", Syn_OK, 1);
      check("ce_acq_pos",  Slip_Pos, SHIFT);

      // Random: occasional bad SHs, random CE, rare resets
      bad_pct = 6;
      for (int i = 0; i < 1500; i++) begin
         send($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, blk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
